// File: rtl/fmap_frame_collector_pkg.sv
// Shared types and default sizing for the pool2 frame collector.
package fmap_pkg;

    localparam int DEF_NBITS  = 16;
    localparam int DEF_NFMAPS = 16;
    localparam int DEF_NBEATS = 25;
    localparam int DEF_CNTW   = 16;
    localparam int BEATW      = $clog2(DEF_NBEATS);

    typedef logic [DEF_NBITS*DEF_NFMAPS-1:0] act_beat_t;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fmap_frame_collector_mem.sv
// Two-bank frame store: one write port, asynchronous read addressed by {bank, beat}.
module frame_bank_mem #(
    parameter int W      = 256,
    parameter int NBEATS = 25,
    parameter int BW     = $clog2(NBEATS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [BW-1:0] wr_beat,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_bank,
    input  logic [BW-1:0] rd_beat,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] bank_data [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [W-1:0] words [NBEATS];

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == 1'(gi))) begin
                words[wr_beat] <= wr_data;
            end
        end

        assign bank_data[gi] = words[rd_beat];
    end

    assign rd_data = bank_data[rd_bank];

endmodule

// File: rtl/fmap_frame_collector.sv
// Collects non-stallable pool2 beats into ping-pong frame banks and replays
// whole frames over a valid/ready stream, dropping frames when both banks are busy.
module fmap_frame_collector
    import fmap_pkg::*;
#(
    parameter int NBITS  = DEF_NBITS,
    parameter int NFMAPS = DEF_NFMAPS,
    parameter int NBEATS = DEF_NBEATS,
    parameter int CNTW   = DEF_CNTW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [NBITS*NFMAPS-1:0] in_act,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBITS*NFMAPS-1:0] out_act,
    output logic                    out_last,
    output logic                    overflow,
    output logic [CNTW-1:0]         frames_in,
    output logic [CNTW-1:0]         frames_dropped
);

    localparam int W  = NBITS * NFMAPS;
    localparam int BW = $clog2(NBEATS);
    localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

    wr_state_e       state_reg;
    logic            wr_bank_reg;
    logic [BW-1:0]   wr_beat_reg;
    logic [BW-1:0]   drop_beat_reg;
    logic            rd_bank_reg;
    logic [BW-1:0]   rd_beat_reg;
    logic [1:0]      full_reg;
    logic [1:0]      full_next;
    logic            overflow_reg;
    logic [CNTW-1:0] frames_in_reg;
    logic [CNTW-1:0] frames_dropped_reg;

    logic bank_busy;
    logic wr_en;
    logic frame_done;
    logic rd_fire;
    logic rd_done;

    // A bank can only be busy at beat 0: once filling starts the bank was free.
    assign bank_busy  = full_reg[wr_bank_reg];
    assign wr_en      = in_valid && !flush && (state_reg == FILL) && !bank_busy;
    assign frame_done = wr_en && (wr_beat_reg == LAST);
    assign rd_fire    = out_valid && out_ready;
    assign rd_done    = rd_fire && (rd_beat_reg == LAST);

    // Writer and reader always target different banks, so set and clear never collide.
    always_comb begin
        full_next = full_reg;
        if (frame_done) full_next[wr_bank_reg] = 1'b1;
        if (rd_done)    full_next[rd_bank_reg] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= FILL;
            wr_bank_reg        <= 1'b0;
            wr_beat_reg        <= '0;
            drop_beat_reg      <= '0;
            rd_bank_reg        <= 1'b0;
            rd_beat_reg        <= '0;
            full_reg           <= '0;
            overflow_reg       <= 1'b0;
            frames_in_reg      <= '0;
            frames_dropped_reg <= '0;
        end else begin
            full_reg <= full_next;

            if (flush) begin
                state_reg     <= FILL;
                wr_beat_reg   <= '0;
                drop_beat_reg <= '0;
            end else if (in_valid) begin
                case (state_reg)
                    FILL: begin
                        if (bank_busy) begin
                            state_reg          <= DROP;
                            drop_beat_reg      <= BW'(1);
                            frames_dropped_reg <= frames_dropped_reg + 1'b1;
                            overflow_reg       <= 1'b1;
                        end else if (wr_beat_reg == LAST) begin
                            wr_beat_reg   <= '0;
                            wr_bank_reg   <= ~wr_bank_reg;
                            frames_in_reg <= frames_in_reg + 1'b1;
                        end else begin
                            wr_beat_reg <= wr_beat_reg + 1'b1;
                        end
                    end
                    DROP: begin
                        if (drop_beat_reg == LAST) begin
                            state_reg     <= FILL;
                            drop_beat_reg <= '0;
                        end else begin
                            drop_beat_reg <= drop_beat_reg + 1'b1;
                        end
                    end
                endcase
            end

            if (rd_fire) begin
                if (rd_done) begin
                    rd_beat_reg <= '0;
                    rd_bank_reg <= ~rd_bank_reg;
                end else begin
                    rd_beat_reg <= rd_beat_reg + 1'b1;
                end
            end
        end
    end

    frame_bank_mem #(
        .W      (W),
        .NBEATS (NBEATS),
        .BW     (BW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_reg),
        .wr_beat (wr_beat_reg),
        .wr_data (in_act),
        .rd_bank (rd_bank_reg),
        .rd_beat (rd_beat_reg),
        .rd_data (out_act)
    );

    assign out_valid      = full_reg[rd_bank_reg];
    assign out_last       = out_valid && (rd_beat_reg == LAST);
    assign overflow       = overflow_reg;
    assign frames_in      = frames_in_reg;
    assign frames_dropped = frames_dropped_reg;

endmodule

// File: doc/fmap_frame_collector.md
Name: fmap_frame_collector

Overview:
- Receive end of the network activation stream.
- Accepts the per-beat pool2 output (valid + NFMAPS×NBITS activation word; the network cannot be stalled) and assembles complete NBEATS-beat frames (5×5 spatial positions) into a two-bank ping-pong store.
- Replays each frame to the downstream consumer (classifier / host DMA) over a valid/ready stream with last-beat marking.
- Absorbs consumer backpressure up to one full frame of slack. Detects and reports frame drops.

Parameters:
- NBITS, 16, bits per activation
- NFMAPS, 16, feature maps per beat; beat width = NBITS*NFMAPS
- NBEATS, 25, beats per frame (5x5 positions, raster order)
- CNTW, 16, width of the frame/drop statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat qualifier; no backpressure path
- in_act  in  NBITS*NFMAPS  input beat
- flush  in  1  abort any partially collected frame
- out_valid  out  1  output beat available
- out_ready  in  1  consumer accepts beat
- out_act  out  NBITS*NFMAPS  output beat
- out_last  out  1  high with final beat (index NBEATS-1) of a frame
- overflow  out  1  sticky: at least one frame dropped since reset
- frames_in  out  CNTW  complete frames stored (wraps)
- frames_dropped  out  CNTW  frames discarded for lack of a free bank (wraps)

Behaviour:
- Reset (rst=1 at clk edge): both banks empty; wr_bank=rd_bank=0; wr_beat=rd_beat=0; write FSM=FILL. Outputs out_valid=0, out_last=0, overflow=0, frames_in=0, frames_dropped=0. out_act is don't-care while out_valid=0. Reset mid-frame discards all stored and partial data.
- Storage: 2 banks × NBEATS words, each NBITS*NFMAPS bits. A per-bank full flag is set by the writer and cleared by the reader.
- Write FSM states: FILL, DROP.
  - FILL, in_valid, wr_beat==0, full[wr_bank]=1:
    - Go to DROP with drop_beat=1.
    - Increment frames_dropped. Set overflow.
    - Beat is not written.
  - FILL, in_valid, bank free:
    - Write mem[wr_bank][wr_beat]; wr_beat++.
    - When wr_beat==NBEATS-1: set full[wr_bank], toggle wr_bank, wr_beat=0, frames_in++.
  - DROP, in_valid: drop_beat++. On the beat reaching NBEATS-1, return to FILL.
  - A bank is never full mid-frame in FILL, because the full check happens only at beat 0.
- flush: takes precedence over in_valid in the same cycle (that beat is discarded).
  - Sets wr_beat=0 and drop_beat=0; FSM returns to FILL.
  - Already-full banks and the read side are unaffected. Counters are unchanged.
- Read side:
  - out_valid = full[rd_bank].
  - out_act = mem[rd_bank][rd_beat].
  - out_last = out_valid && rd_beat==NBEATS-1.
  - On out_valid && out_ready: rd_beat++. On the last beat: clear full[rd_bank], toggle rd_bank, rd_beat=0.
  - out_act and out_last hold stable while out_valid=1 && out_ready=0.
- Latency: the final input beat of a frame written at edge N gives out_valid=1 with beat 0 in the cycle after edge N. Full throughput: one beat per cycle when out_ready=1.
- Simultaneous events:
  - The writer setting full on one bank and the reader clearing full on the other bank in the same cycle both take effect.
  - A bank released by the reader at edge N is available to a writer beat-0 check at edge N+1, not at edge N.
- Counters wrap modulo 2^CNTW. overflow clears only on rst.
- Frame order is preserved: the reader always drains the oldest full bank.

Decomposition:
- Shared package fmap_pkg holds:
  - typedef act_beat_t (logic [NBITS*NFMAPS-1:0])
  - enum wr_state_e {FILL, DROP}
  - localparam BEATW = $clog2(NBEATS)
- One sub-module, frame_bank_mem: 2×NBEATS register-array storage with 1 write port and 1 asynchronous read port, indexed by {bank, beat}.
- FSM, flags and counters live in the top.

Test Plan:
- Single frame, out_ready=1: 25 beats with in_act=beat index → out_valid rises the cycle after beat 24. Output is 0..24 in order, out_last only on 24, frames_in=1.
- Backpressure, 2 frames: out_ready=0 while frames A(0..24) and B(100..124) arrive, then release → A then B out in order, each out_last once, overflow=0, frames_in=2.
- Overflow: out_ready=0, 3 back-to-back frames → third frame dropped, frames_dropped=1, overflow=1. After draining, a 4th frame is stored and replayed correctly.
- flush mid-frame: 10 beats, flush, then a full frame 200..224 → only 200..224 output, frames_in=1. Flush coincident with in_valid discards that beat.
- Flush during DROP: flush at drop_beat=5, then a frame arrives after a bank frees → it is accepted from beat 0.
- Reset mid-replay: rst asserted while rd_beat=12 → next cycle out_valid=0, counters=0, overflow=0. A subsequent frame replays from beat 0.
